// File: rtl/matrix_wr_arbiter_pkg.sv
// Shared types and widths for the matrix storage write-port arbiter.
package matrix_wr_arbiter_pkg;

  localparam int MAT_ID_W      = 3;
  localparam int ROW_IDX_W     = 2;
  localparam int COL_IDX_W     = 2;
  localparam int ELEM_W        = 8;
  localparam int MAX_ROWS      = 4;
  localparam int MAX_COLS      = 4;
  localparam int NUM_MAT_SLOTS = 8;

  typedef logic [ELEM_W-1:0]                    matrix_element_t;
  typedef logic [MAX_ROWS*MAX_COLS*ELEM_W-1:0]  matrix_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_IC, SRC_CLR} wr_src_t;
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE}              clr_state_t;

  typedef struct packed {
    logic                 wr_en;
    logic                 clear;
    logic                 set_dims;
    logic                 load_all;
    logic                 single;
    logic [ROW_IDX_W-1:0] dims_r;
    logic [COL_IDX_W-1:0] dims_c;
    logic [ROW_IDX_W-1:0] row_idx;
    logic [COL_IDX_W-1:0] col_idx;
    matrix_element_t      val_scalar;
    logic [MAT_ID_W-1:0]  target_id;
    matrix_t              val_matrix;
  } wr_cmd_t;

  // An IC command is legal only when exactly one command bit is set.
  function automatic logic ic_cmd_legal(input logic set_dims, input logic single);
    return set_dims ^ single;
  endfunction

endpackage

// File: rtl/matrix_wr_arbiter_if.sv
// Request/ack sources and storage write-port bundle; master = sources/storage side, slave = arbiter.
interface matrix_wr_arbiter_if;
  import matrix_wr_arbiter_pkg::*;

  logic                 ic_req;
  logic                 ic_cmd_set_dims;
  logic                 ic_cmd_single;
  logic [MAT_ID_W-1:0]  ic_target_id;
  logic [ROW_IDX_W-1:0] ic_dims_r;
  logic [COL_IDX_W-1:0] ic_dims_c;
  logic [ROW_IDX_W-1:0] ic_row_idx;
  logic [COL_IDX_W-1:0] ic_col_idx;
  matrix_element_t      ic_data;
  logic                 ic_ack;
  logic                 alu_req;
  logic [MAT_ID_W-1:0]  alu_target_id;
  matrix_t              alu_matrix;
  logic                 alu_ack;
  logic                 clr_start;
  logic                 clr_busy;
  logic                 clr_done;
  logic                 cmd_err;
  logic                 ms_wr_en;
  logic                 ms_wr_cmd_clear;
  logic                 ms_wr_cmd_set_dims;
  logic                 ms_wr_cmd_load_all;
  logic                 ms_wr_cmd_single;
  logic [ROW_IDX_W-1:0] ms_wr_dims_r;
  logic [COL_IDX_W-1:0] ms_wr_dims_c;
  logic [ROW_IDX_W-1:0] ms_wr_row_idx;
  logic [COL_IDX_W-1:0] ms_wr_col_idx;
  matrix_element_t      ms_wr_val_scalar;
  logic [MAT_ID_W-1:0]  ms_wr_target_id;
  matrix_t              ms_wr_val_matrix;

  modport master (
    output ic_req, ic_cmd_set_dims, ic_cmd_single, ic_target_id, ic_dims_r, ic_dims_c,
           ic_row_idx, ic_col_idx, ic_data, alu_req, alu_target_id, alu_matrix, clr_start,
    input  ic_ack, alu_ack, clr_busy, clr_done, cmd_err, ms_wr_en, ms_wr_cmd_clear,
           ms_wr_cmd_set_dims, ms_wr_cmd_load_all, ms_wr_cmd_single, ms_wr_dims_r,
           ms_wr_dims_c, ms_wr_row_idx, ms_wr_col_idx, ms_wr_val_scalar, ms_wr_target_id,
           ms_wr_val_matrix
  );

  modport slave (
    input  ic_req, ic_cmd_set_dims, ic_cmd_single, ic_target_id, ic_dims_r, ic_dims_c,
           ic_row_idx, ic_col_idx, ic_data, alu_req, alu_target_id, alu_matrix, clr_start,
    output ic_ack, alu_ack, clr_busy, clr_done, cmd_err, ms_wr_en, ms_wr_cmd_clear,
           ms_wr_cmd_set_dims, ms_wr_cmd_load_all, ms_wr_cmd_single, ms_wr_dims_r,
           ms_wr_dims_c, ms_wr_row_idx, ms_wr_col_idx, ms_wr_val_scalar, ms_wr_target_id,
           ms_wr_val_matrix
  );

endinterface

// File: rtl/matrix_clear_seq.sv
// Clear-sweep sequencer: requests one clear per slot 0..NUM_SLOTS-1, advancing on each grant.
// Request is held continuously while running; the slot only advances when granted.
module matrix_clear_seq
  import matrix_wr_arbiter_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_MAT_SLOTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_start_i,
  input  logic                grant_i,
  output logic                req_o,
  output logic [MAT_ID_W-1:0] slot_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [MAT_ID_W-1:0] LAST_SLOT = MAT_ID_W'(NUM_SLOTS - 1);

  clr_state_t          state_q, state_d;
  logic [MAT_ID_W-1:0] slot_q, slot_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      C_IDLE: begin
        if (clr_start_i) begin
          state_d = C_RUN;
          slot_d  = '0;
        end
      end
      C_RUN: begin
        if (grant_i) begin
          slot_d = slot_q + MAT_ID_W'(1);
          if (slot_q == LAST_SLOT) state_d = C_DONE;
        end
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    req_o  = (state_q == C_RUN);
    busy_o = (state_q != C_IDLE);
    done_o = (state_q == C_DONE);
    slot_o = slot_q;
  end

endmodule

// File: rtl/matrix_wr_arbiter.sv
// Shares the matrix storage write port between ALU write-back, input controller and clear sweep.
// One registered write per grant, visible the cycle after the request is sampled; one write per cycle.
module matrix_wr_arbiter
  import matrix_wr_arbiter_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_MAT_SLOTS
) (
  input  logic                clk,
  input  logic                rst,
  matrix_wr_arbiter_if.slave  bus
);

  logic                clr_req, clr_grant, clr_busy, clr_done;
  logic [MAT_ID_W-1:0] clr_slot;
  wr_src_t             src;
  logic                ic_vld, alu_vld;
  logic                rr_q, rr_d;
  logic                ic_ack_q, ic_ack_d, alu_ack_q, alu_ack_d, err_q, err_d;
  logic                busy_q, done_q;
  wr_cmd_t             cmd_q, cmd_d;

  matrix_clear_seq #(.NUM_SLOTS(NUM_SLOTS)) u_clear_seq (
    .clk         (clk),
    .rst         (rst),
    .clr_start_i (bus.clr_start),
    .grant_i     (clr_grant),
    .req_o       (clr_req),
    .slot_o      (clr_slot),
    .busy_o      (clr_busy),
    .done_o      (clr_done)
  );

  // A source acked this cycle still holds req; mask it so it is not granted twice.
  assign ic_vld    = bus.ic_req  & ~ic_ack_q;
  assign alu_vld   = bus.alu_req & ~alu_ack_q;
  assign clr_grant = (src == SRC_CLR);

  // rr_q = 0 favours IC, 1 favours CLR; ALU always wins outright.
  always_comb begin
    src = SRC_NONE;
    if (alu_vld)               src = SRC_ALU;
    else if (ic_vld && clr_req) src = rr_q ? SRC_CLR : SRC_IC;
    else if (ic_vld)           src = SRC_IC;
    else if (clr_req)          src = SRC_CLR;
  end

  always_comb begin
    cmd_d     = '0;
    ic_ack_d  = 1'b0;
    alu_ack_d = 1'b0;
    err_d     = 1'b0;
    rr_d      = rr_q;
    case (src)
      SRC_ALU: begin
        alu_ack_d        = 1'b1;
        cmd_d.wr_en      = 1'b1;
        cmd_d.load_all   = 1'b1;
        cmd_d.target_id  = bus.alu_target_id;
        cmd_d.val_matrix = bus.alu_matrix;
      end
      SRC_IC: begin
        ic_ack_d = 1'b1;
        rr_d     = 1'b1;
        if (ic_cmd_legal(bus.ic_cmd_set_dims, bus.ic_cmd_single)) begin
          cmd_d.wr_en      = 1'b1;
          cmd_d.set_dims   = bus.ic_cmd_set_dims;
          cmd_d.single     = bus.ic_cmd_single;
          cmd_d.dims_r     = bus.ic_dims_r;
          cmd_d.dims_c     = bus.ic_dims_c;
          cmd_d.row_idx    = bus.ic_row_idx;
          cmd_d.col_idx    = bus.ic_col_idx;
          cmd_d.val_scalar = bus.ic_data;
          cmd_d.target_id  = bus.ic_target_id;
        end else begin
          err_d = 1'b1;
        end
      end
      SRC_CLR: begin
        rr_d            = 1'b0;
        cmd_d.wr_en     = 1'b1;
        cmd_d.clear     = 1'b1;
        cmd_d.target_id = clr_slot;
      end
      default: ;
    endcase
  end

  // Sweep status is registered alongside the write so busy/done line up with the clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= '0;
      ic_ack_q  <= 1'b0;
      alu_ack_q <= 1'b0;
      err_q     <= 1'b0;
      rr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      ic_ack_q  <= ic_ack_d;
      alu_ack_q <= alu_ack_d;
      err_q     <= err_d;
      rr_q      <= rr_d;
      busy_q    <= clr_busy;
      done_q    <= clr_done;
    end
  end

  assign bus.ic_ack             = ic_ack_q;
  assign bus.alu_ack            = alu_ack_q;
  assign bus.cmd_err            = err_q;
  assign bus.clr_busy           = busy_q;
  assign bus.clr_done           = done_q;
  assign bus.ms_wr_en           = cmd_q.wr_en;
  assign bus.ms_wr_cmd_clear    = cmd_q.clear;
  assign bus.ms_wr_cmd_set_dims = cmd_q.set_dims;
  assign bus.ms_wr_cmd_load_all = cmd_q.load_all;
  assign bus.ms_wr_cmd_single   = cmd_q.single;
  assign bus.ms_wr_dims_r       = cmd_q.dims_r;
  assign bus.ms_wr_dims_c       = cmd_q.dims_c;
  assign bus.ms_wr_row_idx      = cmd_q.row_idx;
  assign bus.ms_wr_col_idx      = cmd_q.col_idx;
  assign bus.ms_wr_val_scalar   = cmd_q.val_scalar;
  assign bus.ms_wr_target_id    = cmd_q.target_id;
  assign bus.ms_wr_val_matrix   = cmd_q.val_matrix;

endmodule

// File: tb/tb_matrix_wr_arbiter.sv
// Directed bench for the write-port arbiter: IC, ALU collision, clear sweep, illegal commands, reset.
module tb_matrix_wr_arbiter;
  import matrix_wr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   k;
  matrix_t pat;

  matrix_wr_arbiter_if bus ();

  matrix_wr_arbiter #(.NUM_SLOTS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.ms_wr_cmd_clear, bus.ms_wr_cmd_set_dims, bus.ms_wr_cmd_load_all, bus.ms_wr_cmd_single};
  endfunction

  task automatic expect_wr(input string tag, input logic en, input logic [3:0] stb,
                           input logic [MAT_ID_W-1:0] tgt);
    chk({tag, "_en"},  128'(bus.ms_wr_en), 128'(en));
    chk({tag, "_stb"}, 128'(strobes()),    128'(stb));
    chk({tag, "_tgt"}, 128'(bus.ms_wr_target_id), 128'(tgt));
  endtask

  initial begin
    rst = 1'b1;
    bus.ic_req = 1'b0; bus.ic_cmd_set_dims = 1'b0; bus.ic_cmd_single = 1'b0;
    bus.ic_target_id = '0; bus.ic_dims_r = '0; bus.ic_dims_c = '0;
    bus.ic_row_idx = '0; bus.ic_col_idx = '0; bus.ic_data = '0;
    bus.alu_req = 1'b0; bus.alu_target_id = '0; bus.alu_matrix = '0; bus.clr_start = 1'b0;

    // Reset state
    step(); step();
    expect_wr("rst", 1'b0, 4'b0000, 3'd0);
    chk("rst_acks", 128'({bus.ic_ack, bus.alu_ack, bus.cmd_err}), 128'(3'b000));
    chk("rst_clr",  128'({bus.clr_busy, bus.clr_done}), 128'(2'b00));
    chk("rst_mat",  128'(bus.ms_wr_val_matrix), 128'd0);
    rst = 1'b0;
    step();

    // Single IC write, req held one cycle past ack
    bus.ic_req = 1'b1; bus.ic_cmd_single = 1'b1; bus.ic_target_id = 3'd2;
    bus.ic_row_idx = 2'd1; bus.ic_col_idx = 2'd0; bus.ic_data = 8'd5;
    step();
    expect_wr("ic1", 1'b1, 4'b0001, 3'd2);
    chk("ic1_pay", 128'({bus.ms_wr_row_idx, bus.ms_wr_col_idx, bus.ms_wr_val_scalar}),
        128'({2'd1, 2'd0, 8'd5}));
    chk("ic1_ack", 128'({bus.ic_ack, bus.alu_ack}), 128'(2'b10));
    step();
    expect_wr("ic1_hold", 1'b0, 4'b0000, 3'd0);
    chk("ic1_hold_ack", 128'(bus.ic_ack), 128'd0);
    bus.ic_req = 1'b0; bus.ic_cmd_single = 1'b0;
    step();

    // ALU and IC collide: ALU first, IC next
    pat = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    bus.alu_req = 1'b1; bus.alu_target_id = 3'd3; bus.alu_matrix = pat;
    bus.ic_req = 1'b1; bus.ic_cmd_set_dims = 1'b1; bus.ic_target_id = 3'd4;
    bus.ic_dims_r = 2'd2; bus.ic_dims_c = 2'd3;
    step();
    expect_wr("col_alu", 1'b1, 4'b0010, 3'd3);
    chk("col_alu_mat", 128'(bus.ms_wr_val_matrix), pat);
    chk("col_alu_ack", 128'({bus.alu_ack, bus.ic_ack}), 128'(2'b10));
    bus.alu_req = 1'b0;
    step();
    expect_wr("col_ic", 1'b1, 4'b0100, 3'd4);
    chk("col_ic_dims", 128'({bus.ms_wr_dims_r, bus.ms_wr_dims_c}), 128'({2'd2, 2'd3}));
    chk("col_ic_ack", 128'({bus.alu_ack, bus.ic_ack}), 128'(2'b01));
    chk("col_ic_mat0", 128'(bus.ms_wr_val_matrix), 128'd0);
    bus.ic_req = 1'b0; bus.ic_cmd_set_dims = 1'b0;
    step();
    expect_wr("col_idle", 1'b0, 4'b0000, 3'd0);

    // Clear sweep alone; a second clr_start mid-sweep is ignored
    bus.clr_start = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      bus.clr_start = (i == 3);
      step();
      expect_wr($sformatf("sw_%0d", i), 1'b1, 4'b1000, 3'(i));
      chk($sformatf("sw_bd_%0d", i), 128'({bus.clr_busy, bus.clr_done}), 128'(2'b10));
    end
    bus.clr_start = 1'b0;
    step();
    expect_wr("sw_end", 1'b0, 4'b0000, 3'd0);
    chk("sw_done", 128'({bus.clr_busy, bus.clr_done}), 128'(2'b11));
    step();
    chk("sw_idle", 128'({bus.clr_busy, bus.clr_done}), 128'(2'b00));
    chk("sw_idle_en", 128'(bus.ms_wr_en), 128'd0);

    // Sweep during an IC stream of 4 requests: IC and CLR alternate
    bus.clr_start = 1'b1;
    bus.ic_req = 1'b1; bus.ic_cmd_single = 1'b1; bus.ic_target_id = 3'd6;
    bus.ic_row_idx = 2'd0; bus.ic_col_idx = 2'd1; bus.ic_data = 8'h10;
    k = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      bus.clr_start = 1'b0;
      if (j < 8 && (j % 2) == 0) begin
        expect_wr($sformatf("mix_ic_%0d", j), 1'b1, 4'b0001, 3'd6);
        chk($sformatf("mix_ic_row_%0d", j), 128'({bus.ms_wr_row_idx, bus.ms_wr_val_scalar}),
            128'({2'(j / 2), 8'(8'h10 + j / 2)}));
        chk($sformatf("mix_ic_ack_%0d", j), 128'(bus.ic_ack), 128'd1);
        k++;
        if (k == 4) begin
          bus.ic_req = 1'b0; bus.ic_cmd_single = 1'b0;
        end else begin
          bus.ic_row_idx = 2'(k); bus.ic_data = 8'(8'h10 + k);
        end
      end else begin
        expect_wr($sformatf("mix_clr_%0d", j), 1'b1, 4'b1000, 3'((j < 8) ? j / 2 : j - 4));
        chk($sformatf("mix_clr_ack_%0d", j), 128'(bus.ic_ack), 128'd0);
      end
      if (j > 0) chk($sformatf("mix_busy_%0d", j), 128'({bus.clr_busy, bus.clr_done}), 128'(2'b10));
    end
    step();
    expect_wr("mix_end", 1'b0, 4'b0000, 3'd0);
    chk("mix_done", 128'({bus.clr_busy, bus.clr_done}), 128'(2'b11));
    step();
    chk("mix_idle", 128'({bus.clr_busy, bus.clr_done}), 128'(2'b00));

    // Illegal IC commands: both bits, then neither bit
    for (int p = 0; p < 2; p++) begin
      bus.ic_req = 1'b1; bus.ic_target_id = 3'd1;
      bus.ic_cmd_set_dims = (p == 0); bus.ic_cmd_single = (p == 0);
      step();
      chk($sformatf("ill_%0d_ackerr", p), 128'({bus.ic_ack, bus.cmd_err}), 128'(2'b11));
      expect_wr($sformatf("ill_%0d", p), 1'b0, 4'b0000, 3'd0);
      bus.ic_req = 1'b0; bus.ic_cmd_set_dims = 1'b0; bus.ic_cmd_single = 1'b0;
      step();
      chk($sformatf("ill_%0d_clear", p), 128'({bus.ic_ack, bus.cmd_err}), 128'(2'b00));
    end

    // Reset after the 3rd clear, with clr_start asserted alongside reset
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_wr($sformatf("rs_%0d", i), 1'b1, 4'b1000, 3'(i));
    end
    rst = 1'b1; bus.clr_start = 1'b1;
    step();
    rst = 1'b0; bus.clr_start = 1'b0;
    expect_wr("rs_rst", 1'b0, 4'b0000, 3'd0);
    chk("rs_rst_clr", 128'({bus.clr_busy, bus.clr_done}), 128'(2'b00));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rs_quiet_%0d", i), 128'({bus.ms_wr_en, bus.clr_busy, bus.clr_done}), 128'(3'b000));
    end
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    step();
    expect_wr("rs_restart0", 1'b1, 4'b1000, 3'd0);
    step();
    expect_wr("rs_restart1", 1'b1, 4'b1000, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
